expr_ascii_tx: RTL

EXPR_ASCII_TX -- requirements
Module: expr_ascii_tx

---
 rtl/expr_ascii_tx_pkg.sv | 58 +++++
 rtl/expr_tok_fifo.sv | 54 +++++
 rtl/expr_ascii_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/expr_ascii_tx_pkg.sv
// Shared definitions for the expression-to-ASCII transmitter: token codes,
// ASCII constants, FSM state encoding, FIFO geometry and the result timeout.
package expr_ascii_tx_pkg;

    // Token codes. 0-15 are operands; anything above TOK_SUB is illegal.
    localparam logic [4:0] TOK_LPAR = 5'd16;
    localparam logic [4:0] TOK_RPAR = 5'd17;
    localparam logic [4:0] TOK_MUL  = 5'd18;
    localparam logic [4:0] TOK_ADD  = 5'd19;
    localparam logic [4:0] TOK_SUB  = 5'd20;

    // ASCII characters sent to the calculator.
    localparam logic [7:0] ASCII_NUL  = 8'h00;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h61;
    localparam logic [7:0] ASCII_LPAR = 8'h28;
    localparam logic [7:0] ASCII_RPAR = 8'h29;
    localparam logic [7:0] ASCII_MUL  = 8'h2A;
    localparam logic [7:0] ASCII_ADD  = 8'h2B;
    localparam logic [7:0] ASCII_SUB  = 8'h2D;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;

    // Token FIFO geometry.
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

    // Cycles spent in WAIT_RES before giving up on the calculator.
    localparam int TIMEOUT_LIMIT = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_SEND_EQ  = 2'd2,
        ST_WAIT_RES = 2'd3
    } state_t;

    // Map a legal token to its character; illegal codes never reach the FIFO.
    function automatic logic [7:0] tok_to_ascii(input logic [4:0] tok);
        logic [7:0] c;
        c = ASCII_NUL;
        if (tok < 5'd10) begin
            c = ASCII_ZERO + {3'b000, tok};
        end else if (tok < 5'd16) begin
            c = ASCII_A + {3'b000, tok} - 8'd10;
        end else begin
            case (tok)
                TOK_LPAR: c = ASCII_LPAR;
                TOK_RPAR: c = ASCII_RPAR;
                TOK_MUL:  c = ASCII_MUL;
                TOK_ADD:  c = ASCII_ADD;
                TOK_SUB:  c = ASCII_SUB;
                default:  c = ASCII_NUL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/expr_tok_fifo.sv
// 16-deep, 5-bit token FIFO. Pointers wrap modulo the depth and a separate
// occupancy counter keeps full and empty unambiguous. Head is read
// combinationally so a pop and its character appear in the same cycle.
module expr_tok_fifo
    import expr_ascii_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [4:0]       i_din,
    input  logic             i_pop,
    output logic [4:0]       o_dout,
    output logic [FIFO_AW:0] o_count
);

    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [4:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_COUNT);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/expr_ascii_tx.sv
// Queues expression tokens, then on start streams them as ASCII followed by
// '=' and waits (bounded) for the calculator's result.
module expr_ascii_tx
    import expr_ascii_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tok_wr,
    input  logic [4:0] tok_in,
    input  logic       start,
    input  logic       calc_valid,
    input  logic [6:0] calc_result,
    output logic [7:0] ascii_out,
    output logic       ready,
    output logic [4:0] tok_count,
    output logic       busy,
    output logic       done,
    output logic [6:0] result,
    output logic       err
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_timeout;
    logic [7:0] w_timeout_next;
    logic [6:0] r_result;
    logic       r_done;
    logic       r_err;

    logic [4:0] w_fifo_head;
    logic [4:0] w_fifo_count;
    logic       w_pop;
    logic       w_push;
    logic       w_start_ok;
    logic       w_wr_ok;
    logic       w_tok_legal;
    logic       w_full;
    logic       w_wr_err;
    logic       w_capture;
    logic       w_timeout_hit;

    // Writes are only considered while idle, and a write coinciding with an
    // accepted start is dropped so the expression is frozen at start.
    assign w_start_ok  = start && (r_state == ST_IDLE) && (w_fifo_count != 5'd0);
    assign w_wr_ok     = tok_wr && (r_state == ST_IDLE) && !w_start_ok;
    assign w_tok_legal = (tok_in <= TOK_SUB);
    assign w_full      = (w_fifo_count == 5'(FIFO_DEPTH));
    assign w_push      = w_wr_ok && w_tok_legal && !w_full;
    assign w_wr_err    = w_wr_ok && (!w_tok_legal || w_full);

    expr_tok_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (tok_in),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    // Next-state, character output and timeout control.
    always_comb begin
        w_state_next   = r_state;
        w_timeout_next = r_timeout;
        w_pop          = 1'b0;
        ascii_out      = ASCII_NUL;
        ready          = 1'b0;
        w_capture      = 1'b0;
        w_timeout_hit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timeout_next = '0;
                if (w_start_ok) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                w_pop     = 1'b1;
                ready     = 1'b1;
                ascii_out = tok_to_ascii(w_fifo_head);
                if (w_fifo_count == 5'd1) w_state_next = ST_SEND_EQ;
            end
            ST_SEND_EQ: begin
                ready          = 1'b1;
                ascii_out      = ASCII_EQ;
                w_timeout_next = '0;
                w_state_next   = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (calc_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_timeout == 8'(TIMEOUT_LIMIT - 1)) begin
                    w_timeout_hit  = 1'b1;
                    w_timeout_next = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_timeout_next = r_timeout + 8'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timeout <= '0;
        end else begin
            r_state   <= w_state_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Result capture, done pulse and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_capture;
            if (w_capture) r_result <= calc_result;
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_wr_err || w_timeout_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign tok_count = w_fifo_count;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign err       = r_err;

endmodule
